// File: rtl/mem_stack_ctrl.sv
// Memory-stage executor: decodes MEM control bundles, owns SP, drives the data memory,
// and captures popped words one cycle later into the return PC / restored flags.
module mem_stack_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int SP_TOP = 2**ADDR_W-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_addr_sel,
  input  logic [2:0]        mem_data_sel,
  input  logic              sp_wr,
  input  logic              flags_wb,
  input  logic [1:0]        pop_l_h,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rsrc_val,
  input  logic [DATA_W-1:0] rdst_val,
  input  logic [3:0]        flags,
  input  logic [31:0]       int_pc,
  input  logic [31:0]       call_pc,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  output logic [ADDR_W-1:0] sp,
  output logic [31:0]       ret_pc,
  output logic              ret_pc_valid,
  output logic [3:0]        flags_restore,
  output logic              flags_restore_en,
  output logic              stack_ovf,
  output logic              stack_unf
);
  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_TOP);

  typedef struct packed {
    logic       pend;
    logic       fwb;
    logic [1:0] plh;
  } tag_t;

  tag_t              tag_q;
  logic              acc, push, pop, ovf, unf;
  logic [ADDR_W-1:0] sp_q, sp_inc, sp_dec;
  logic [15:0]       rd16;
  logic              unused_bits;

  assign acc    = valid & ~stall;
  // A bundle with both read and write is treated as a push for SP purposes.
  assign push   = acc & mem_write & sp_wr;
  assign pop    = acc & mem_read & sp_wr & ~mem_write;
  assign ovf    = push & (sp_q == '0);
  assign unf    = pop & (sp_q == SP_RST);
  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);
  assign rd16   = 16'(dmem_rdata);
  assign sp     = sp_q;

  assign dmem_we = acc & mem_write & ~ovf;
  assign dmem_re = acc & mem_read & ~unf;
  assign flags_restore_en = tag_q.pend & tag_q.fwb;

  assign unused_bits = ^{alu_result, rsrc_val, dmem_rdata};

  always_comb begin
    dmem_addr = sp_q;
    case (mem_addr_sel)
      2'b00:   dmem_addr = ADDR_W'(alu_result);
      2'b01:   dmem_addr = ADDR_W'(rsrc_val);
      2'b10:   dmem_addr = sp_inc;
      default: dmem_addr = sp_q;
    endcase
  end

  always_comb begin
    dmem_wdata = '0;
    case (mem_data_sel)
      3'b000:  dmem_wdata = rsrc_val;
      3'b001:  dmem_wdata = rdst_val;
      3'b010:  dmem_wdata = DATA_W'(flags);
      3'b011:  dmem_wdata = DATA_W'(int_pc[15:0]);
      3'b100:  dmem_wdata = DATA_W'(int_pc[31:16]);
      3'b101:  dmem_wdata = DATA_W'(call_pc[15:0]);
      3'b110:  dmem_wdata = DATA_W'(call_pc[31:16]);
      default: dmem_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q          <= SP_RST;
      ret_pc        <= '0;
      ret_pc_valid  <= 1'b0;
      flags_restore <= '0;
      stack_ovf     <= 1'b0;
      stack_unf     <= 1'b0;
      tag_q         <= '0;
    end else begin
      if (push && !ovf)     sp_q <= sp_dec;
      else if (pop && !unf) sp_q <= sp_inc;
      if (ovf) stack_ovf <= 1'b1;
      if (unf) stack_unf <= 1'b1;
      // Tag rides one cycle behind the read; it is consumed regardless of stall.
      tag_q.pend <= dmem_re;
      tag_q.fwb  <= flags_wb;
      tag_q.plh  <= pop_l_h;
      if (tag_q.pend) begin
        if (tag_q.fwb) flags_restore <= rd16[3:0];
        if (tag_q.plh == 2'b10) begin
          ret_pc[15:0] <= rd16;
          ret_pc_valid <= 1'b0;
        end else if (tag_q.plh == 2'b11) begin
          ret_pc[31:16] <= rd16;
          ret_pc_valid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Bench for mem_stack_ctrl: issue-decode vector table, stack sequences, and a
// scoreboard of expected flag-restore strobes keyed by cycle.
module tb_mem_stack_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        valid, stall, mem_read, mem_write, sp_wr, flags_wb;
  logic [1:0]  mem_addr_sel, pop_l_h;
  logic [2:0]  mem_data_sel;
  logic [15:0] alu_result, rsrc_val, rdst_val, dmem_rdata, dmem_wdata;
  logic [3:0]  flags, flags_restore;
  logic [31:0] int_pc, call_pc, ret_pc;
  logic [11:0] dmem_addr, sp;
  logic        dmem_we, dmem_re, ret_pc_valid, flags_restore_en, stack_ovf, stack_unf;

  logic [15:0] mem [0:4095];
  int checks = 0, failures = 0, cyc = 0;
  int sb[$];

  typedef struct {
    logic rd, wr; logic [1:0] asel; logic [2:0] dsel; logic spw, fwb; logic [1:0] plh;
    logic e_we, e_re; logic [11:0] e_addr; logic [15:0] e_wdata;
  } vec_t;

  mem_stack_ctrl dut (
    .clk(clk), .rst(rst), .valid(valid), .stall(stall), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr_sel(mem_addr_sel), .mem_data_sel(mem_data_sel),
    .sp_wr(sp_wr), .flags_wb(flags_wb), .pop_l_h(pop_l_h), .alu_result(alu_result),
    .rsrc_val(rsrc_val), .rdst_val(rdst_val), .flags(flags), .int_pc(int_pc),
    .call_pc(call_pc), .dmem_rdata(dmem_rdata), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re), .sp(sp),
    .ret_pc(ret_pc), .ret_pc_valid(ret_pc_valid), .flags_restore(flags_restore),
    .flags_restore_en(flags_restore_en), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= mem[dmem_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] asel, input logic [2:0] dsel,
                              input logic spw, fwb, input logic [1:0] plh, input logic ewe, ere,
                              input logic [11:0] ea, input logic [15:0] ewd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.asel = asel; v.dsel = dsel; v.spw = spw; v.fwb = fwb; v.plh = plh;
    v.e_we = ewe; v.e_re = ere; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  // One clock: scoreboard check, drive at negedge, check issue outputs, advance.
  task automatic step(input vec_t v, input logic vld, input logic stl, input logic chk);
    logic exp_en;
    @(negedge clk);
    exp_en = (sb.size() > 0 && sb[0] == cyc);
    if (exp_en) void'(sb.pop_front());
    check("flags_restore_en", {31'b0, flags_restore_en}, {31'b0, exp_en});
    valid = vld; stall = stl; mem_read = v.rd; mem_write = v.wr; mem_addr_sel = v.asel;
    mem_data_sel = v.dsel; sp_wr = v.spw; flags_wb = v.fwb; pop_l_h = v.plh;
    #1;
    if (chk) begin
      check("dmem_we", {31'b0, dmem_we}, {31'b0, v.e_we});
      check("dmem_re", {31'b0, dmem_re}, {31'b0, v.e_re});
      check("dmem_addr", {20'b0, dmem_addr}, {20'b0, v.e_addr});
      check("dmem_wdata", {16'b0, dmem_wdata}, {16'b0, v.e_wdata});
    end
    if (vld && !stl && v.e_re && v.fwb) sb.push_back(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  vec_t tbl [11];
  vec_t nop, pushv;

  initial begin
    valid = 0; stall = 0; mem_read = 0; mem_write = 0; mem_addr_sel = 0; mem_data_sel = 0;
    sp_wr = 0; flags_wb = 0; pop_l_h = 0; dmem_rdata = 0;
    alu_result = 16'h5ABC; rsrc_val = 16'hBEEF; rdst_val = 16'h1234; flags = 4'hA;
    int_pc = 32'h1111_2222; call_pc = 32'h0001_0042;
    nop = mk(0,0,2'b00,3'b111,0,0,2'b00, 0,0,12'h0,16'h0);

    tbl[0]  = mk(0,1,2'b00,3'b000,0,0,2'b00, 1,0,12'hABC,16'hBEEF);
    tbl[1]  = mk(0,1,2'b01,3'b001,0,0,2'b00, 1,0,12'hEEF,16'h1234);
    tbl[2]  = mk(0,1,2'b00,3'b010,0,0,2'b00, 1,0,12'hABC,16'h000A);
    tbl[3]  = mk(0,1,2'b00,3'b011,0,0,2'b00, 1,0,12'hABC,16'h2222);
    tbl[4]  = mk(0,1,2'b00,3'b100,0,0,2'b00, 1,0,12'hABC,16'h1111);
    tbl[5]  = mk(0,1,2'b00,3'b101,0,0,2'b00, 1,0,12'hABC,16'h0042);
    tbl[6]  = mk(0,1,2'b00,3'b110,0,0,2'b00, 1,0,12'hABC,16'h0001);
    tbl[7]  = mk(0,1,2'b00,3'b111,0,0,2'b00, 1,0,12'hABC,16'h0000);
    tbl[8]  = mk(1,0,2'b01,3'b111,0,0,2'b00, 0,1,12'hEEF,16'h0000);
    tbl[9]  = mk(0,1,2'b10,3'b111,0,0,2'b00, 1,0,12'h000,16'h0000);
    tbl[10] = mk(0,1,2'b11,3'b111,0,0,2'b00, 1,0,12'hFFF,16'h0000);

    repeat (2) @(posedge clk);
    #1;
    check("reset sp", {20'b0, sp}, 32'hFFF);
    check("reset ret_pc", ret_pc, 32'h0);
    check("reset ret_pc_valid", {31'b0, ret_pc_valid}, 32'h0);
    check("reset flags_restore", {28'b0, flags_restore}, 32'h0);
    check("reset flags_en", {31'b0, flags_restore_en}, 32'h0);
    check("reset ovf/unf", {30'b0, stack_ovf, stack_unf}, 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 11; i++) step(tbl[i], 1, 0, 1);
    check("sp after table", {20'b0, sp}, 32'hFFF);

    // PUSH rdst then pop it back
    step(mk(0,1,2'b11,3'b001,1,0,2'b00, 1,0,12'hFFF,16'h1234), 1, 0, 1);
    check("sp after push", {20'b0, sp}, 32'hFFE);
    step(mk(1,0,2'b10,3'b111,1,0,2'b00, 0,1,12'hFFF,16'h0), 1, 0, 1);
    check("sp after pop", {20'b0, sp}, 32'hFFF);

    // CALL / RET
    step(mk(0,1,2'b11,3'b110,1,0,2'b00, 1,0,12'hFFF,16'h0001), 1, 0, 1);
    step(mk(0,1,2'b11,3'b101,1,0,2'b00, 1,0,12'hFFE,16'h0042), 1, 0, 1);
    check("sp after call", {20'b0, sp}, 32'hFFD);
    step(mk(1,0,2'b10,3'b111,1,0,2'b10, 0,1,12'hFFE,16'h0), 1, 0, 1);
    step(mk(1,0,2'b10,3'b111,1,0,2'b11, 0,1,12'hFFF,16'h0), 1, 0, 1);
    step(nop, 0, 0, 0);
    check("ret_pc call", ret_pc, 32'h0001_0042);
    check("ret_pc_valid call", {31'b0, ret_pc_valid}, 32'h1);
    check("sp after ret", {20'b0, sp}, 32'hFFF);

    // Interrupt / RETI; capture must survive a stall in the following cycle
    step(mk(0,1,2'b11,3'b010,1,0,2'b00, 1,0,12'hFFF,16'h000A), 1, 0, 1);
    step(mk(0,1,2'b11,3'b100,1,0,2'b00, 1,0,12'hFFE,16'h1111), 1, 0, 1);
    step(mk(0,1,2'b11,3'b011,1,0,2'b00, 1,0,12'hFFD,16'h2222), 1, 0, 1);
    check("sp after int", {20'b0, sp}, 32'hFFC);
    step(mk(1,0,2'b10,3'b111,1,0,2'b10, 0,1,12'hFFD,16'h0), 1, 0, 1);
    step(nop, 0, 0, 0);
    check("ret_pc low half", ret_pc, 32'h0001_2222);
    check("ret_pc_valid drop", {31'b0, ret_pc_valid}, 32'h0);
    step(mk(1,0,2'b10,3'b111,1,0,2'b11, 0,1,12'hFFE,16'h0), 1, 0, 1);
    step(mk(1,0,2'b10,3'b111,1,1,2'b00, 0,1,12'hFFF,16'h0), 1, 0, 1);
    step(nop, 1, 1, 0);
    step(nop, 0, 0, 0);
    check("ret_pc reti", ret_pc, 32'h1111_2222);
    check("ret_pc_valid reti", {31'b0, ret_pc_valid}, 32'h1);
    check("flags_restore", {28'b0, flags_restore}, 32'hA);
    check("sp after reti", {20'b0, sp}, 32'hFFF);

    // Stall holds a push; release executes it once
    pushv = mk(0,1,2'b11,3'b001,1,0,2'b00, 1,0,12'hFFF,16'h1234);
    step(mk(0,1,2'b11,3'b001,1,0,2'b00, 0,0,12'hFFF,16'h1234), 1, 1, 1);
    check("sp stalled", {20'b0, sp}, 32'hFFF);
    step(pushv, 1, 0, 1);
    check("sp released", {20'b0, sp}, 32'hFFE);

    // Reset while a flag pop is in flight
    step(mk(1,0,2'b10,3'b111,1,1,2'b00, 0,1,12'hFFF,16'h0), 1, 0, 1);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    sb.delete();
    check("sp after mid reset", {20'b0, sp}, 32'hFFF);
    check("ret_pc after mid reset", ret_pc, 32'h0);
    step(nop, 0, 0, 0);
    step(nop, 0, 0, 0);

    // Underflow
    step(mk(1,0,2'b10,3'b111,1,1,2'b00, 0,0,12'h000,16'h0), 1, 0, 1);
    check("stack_unf", {31'b0, stack_unf}, 32'h1);
    check("sp underflow", {20'b0, sp}, 32'hFFF);
    step(nop, 0, 0, 0);

    // Fill to SP=0 then overflow
    pushv = mk(0,1,2'b11,3'b111,1,0,2'b00, 1,0,12'h0,16'h0);
    for (int i = 0; i < 4095; i++) step(pushv, 1, 0, 0);
    check("sp full", {20'b0, sp}, 32'h0);
    check("ovf before", {31'b0, stack_ovf}, 32'h0);
    step(mk(0,1,2'b11,3'b111,1,0,2'b00, 0,0,12'h000,16'h0), 1, 0, 1);
    step(nop, 0, 0, 0);
    check("stack_ovf", {31'b0, stack_ovf}, 32'h1);
    check("sp overflow", {20'b0, sp}, 32'h0);
    check("unf sticky", {31'b0, stack_unf}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stack_ctrl.md
Name: mem_stack_ctrl

Overview:
- Memory-stage decoder/executor for the MEM/WB control bundles that decode emits: memRead, memWrite, memAddress(2), memData(3), sp_wr, flags_wb, pop_l_h(2).
- Owns the stack pointer and drives the synchronous data memory.
- Reassembles the 32-bit return PC from two popped 16-bit halves, and restores flags on RETI.
- Feeds the fetch-stage PC mux used when jump_sel=11.

Parameters:
- DATA_W, 16, data/memory word width
- ADDR_W, 12, data memory address width
- SP_TOP, 2**ADDR_W-1, SP reset value (empty stack)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- valid  in  1  EX/MEM bundle holds a real instruction
- stall  in  1  hold: command ignored, no state change
- mem_read  in  1  read request
- mem_write  in  1  write request
- mem_addr_sel  in  2  00 alu_result, 01 rsrc_val, 10 SP+1 (pop), 11 SP (push)
- mem_data_sel  in  3  000 rsrc_val, 001 rdst_val, 010 {12'b0,flags}, 011 int_pc[15:0], 100 int_pc[31:16], 101 call_pc[15:0], 110 call_pc[31:16], 111 zero
- sp_wr  in  1  update SP (push/pop)
- flags_wb  in  1  popped word restores flags
- pop_l_h  in  2  00 normal, 10 PC low half, 11 PC high half
- alu_result  in  DATA_W  effective address
- rsrc_val, rdst_val  in  DATA_W  register operands
- flags  in  4  current CCR
- int_pc, call_pc  in  32  PCs to save
- dmem_rdata  in  DATA_W  memory read data, valid cycle after dmem_re
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  DATA_W  write data
- dmem_we, dmem_re  out  1  strobes
- sp  out  ADDR_W  current SP
- ret_pc  out  32  assembled return PC
- ret_pc_valid  out  1  ret_pc complete
- flags_restore  out  4  popped flags
- flags_restore_en  out  1  one-cycle flag load strobe
- stack_ovf, stack_unf  out  1  sticky error flags

Behaviour:
- Reset (rst=0, async): sp=SP_TOP; ret_pc=0; ret_pc_valid=0; flags_restore=0; flags_restore_en=0; stack_ovf=0; stack_unf=0.
- Reset while a pop is in flight discards the pending capture.
- Command accepted when valid=1 and stall=0. Otherwise dmem_we=dmem_re=0 and all registers hold.
- Issue (combinational, cycle N):
  - dmem_we=mem_write; dmem_re=mem_read.
  - dmem_addr by mem_addr_sel, truncated to ADDR_W.
  - dmem_wdata by mem_data_sel.
- Push (mem_write & sp_wr): write at SP; SP<=SP-1 at end of N.
- Pop (mem_read & sp_wr): address SP+1; SP<=SP+1 at end of N.
- sp_wr with neither read nor write: SP unchanged.
- Overflow: push with SP==0 -> dmem_we forced 0, SP held, stack_ovf<=1.
- Underflow: pop with SP==SP_TOP -> dmem_re forced 0, SP held, stack_unf<=1, no capture scheduled.
- Errors are cleared only by reset.
- Capture (cycle N+1): a one-entry tag register (pop_l_h, flags_wb, pending) is latched at N and applied to dmem_rdata at N+1.
  - pop_l_h=10: ret_pc[15:0]<=rdata; ret_pc_valid<=0.
  - pop_l_h=11: ret_pc[31:16]<=rdata; ret_pc_valid<=1 from N+2, held until the next pop_l_h=10 capture.
  - flags_wb: flags_restore<=rdata[3:0]; flags_restore_en=1 for exactly one cycle (N+1, combinational from the tag).
  - Capture proceeds even if stall is asserted in N+1, because the tag was already accepted.
- Pop order is low then high (LIFO of a high-then-low push sequence).
- Back-to-back pops: capture of N and issue of N+1 occur in the same cycle. Independent, no bubble.
- SP arithmetic is modulo 2**ADDR_W; only the checks above guard wrap.

Test Plan:
- Reset: sp=0xFFF, ret_pc=0, all strobes 0. Assert rst mid-pop -> no flags_restore_en afterwards.
- PUSH rdst_val=0x1234, sel 11/001 -> dmem_we=1, addr 0xFFF, wdata 0x1234; next cycle sp=0xFFE.
- CALL sequence, call_pc=0x0001_0042: push sel 110 then 101 -> mem[0xFFF]=0x0001, mem[0xFFE]=0x0042, sp=0xFFD. Then RET pops 10 and 11 -> ret_pc=0x00010042, ret_pc_valid=1, sp=0xFFF.
- Interrupt then RETI: push flags=0xA, int_pc high, int_pc low. Pop flags -> flags_restore=0xA with a one-cycle en. Two PC pops restore int_pc.
- Pop at SP_TOP -> dmem_re=0, stack_unf=1, sp unchanged. Force sp=0 and push -> dmem_we=0, stack_ovf=1.
- stall=1 with a valid push -> no write, sp unchanged. Release -> push executes once.
